text_console_writer: RTL and testbench

TEXT_CONSOLE_WRITER -- requirements
Module: text_console_writer

---
 rtl/text_console_writer.sv | 228 ++++++++++++++++++++++
 tb/tb_text_console_writer.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/text_console_writer.sv
// text_console_writer
// Turns a stream of character bytes into writes to a COLS x ROWS text memory.
// A cursor (row, col) tracks where the next printable byte lands. LF, CR and
// backspace move the cursor. A clean request blanks the whole screen with
// spaces, one cell per cycle.
//
// Optional feature macro: TEXT_CONSOLE_SCROLL_WRAP_EN
//   defined   : every row advance blanks the new row (LINECLR). The row after
//               the last one is row 0, so the screen never fills.
//   undefined : a row advance past the last row parks the writer in FULL
//               until a clean request or reset.
//
// Ports
//   i_clk      clock, rising edge
//   i_rst      asynchronous active-high reset
//   i_valid    character byte offered on i_data
//   i_data     character byte
//   o_ready    high in IDLE; a byte is taken on i_valid & o_ready & !i_clean
//   i_clean    clear-screen request, sampled every cycle
//   o_address  text memory address {row, col}
//   o_data     byte written to text memory
//   o_we       text memory write strobe, one cycle per cell
//   o_full     screen full, no further text accepted
//   o_busy     high while a screen clear or line clear is running
module text_console_writer #(
  parameter int COLS   = 80,
  parameter int ROWS   = 30,
  parameter int COL_W  = 7,
  parameter int ROW_W  = 5,
  parameter int ADDR_W = ROW_W + COL_W
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  input  logic [7:0]        i_data,
  output logic              o_ready,
  input  logic              i_clean,
  output logic [ADDR_W-1:0] o_address,
  output logic [7:0]        o_data,
  output logic              o_we,
  output logic              o_full,
  output logic              o_busy
);

  localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);
  localparam logic [7:0]       CH_LF    = 8'h0A;
  localparam logic [7:0]       CH_CR    = 8'h0D;
  localparam logic [7:0]       CH_BS    = 8'h08;
  localparam logic [7:0]       CH_SP    = 8'h20;

`ifdef TEXT_CONSOLE_SCROLL_WRAP_EN
  localparam bit SCROLL = 1'b1;
`else
  localparam bit SCROLL = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_CLEAR,
    S_LINECLR,
    S_FULL
  } state_t;

  state_t           state;
  logic [ROW_W-1:0] row;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] clr_row;
  logic [COL_W-1:0] clr_col;
  // WRITE advances the cursor after a printable byte, but not after the
  // space that backspace leaves behind (the cursor already moved back).
  logic             write_adv;

  logic             last_row;
  logic             last_col;
  logic [ROW_W-1:0] adv_row;
  logic [COL_W-1:0] col_dec;
  logic             clr_done;
  logic [ROW_W-1:0] clr_row_nxt;
  logic [COL_W-1:0] clr_col_nxt;

  always_comb begin
    last_row    = (row == LAST_ROW);
    last_col    = (col == LAST_COL);
    adv_row     = last_row ? '0 : row + 1'b1;
    col_dec     = col - 1'b1;
    clr_done    = (clr_row == LAST_ROW) && (clr_col == LAST_COL);
    clr_col_nxt = clr_col + 1'b1;
    clr_row_nxt = clr_row;
    if (clr_col == LAST_COL) begin
      clr_col_nxt = '0;
      clr_row_nxt = clr_row + 1'b1;
    end
  end

  // Status flags are straight decodes of the state register.
  assign o_ready = (state == S_IDLE);
  assign o_full  = (state == S_FULL);
  assign o_busy  = (state == S_CLEAR) || (state == S_LINECLR);

  // Every sweep (screen clear or line clear) puts its first cell on the
  // outputs in the same edge that enters the sweep state, so the sweep
  // state holds o_we high for exactly one cycle per cell.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state     <= S_IDLE;
      row       <= '0;
      col       <= '0;
      clr_row   <= '0;
      clr_col   <= '0;
      write_adv <= 1'b0;
      o_we      <= 1'b0;
      o_address <= '0;
      o_data    <= '0;
    end else begin
      o_we <= 1'b0;
      if (i_clean && (state != S_CLEAR)) begin
        // A write already on the outputs this cycle still lands; the clean
        // then overwrites the whole screen anyway.
        state     <= S_CLEAR;
        clr_row   <= '0;
        clr_col   <= '0;
        o_we      <= 1'b1;
        o_address <= '0;
        o_data    <= CH_SP;
      end else begin
        case (state)
          S_IDLE: begin
            if (i_valid) begin
              case (i_data)
                CH_LF: begin
                  col <= '0;
                  row <= adv_row;
                  if (SCROLL) begin
                    state     <= S_LINECLR;
                    clr_col   <= '0;
                    o_we      <= 1'b1;
                    o_address <= {adv_row, {COL_W{1'b0}}};
                    o_data    <= CH_SP;
                  end else if (last_row) begin
                    state <= S_FULL;
                  end
                end
                CH_CR: begin
                  col <= '0;
                end
                CH_BS: begin
                  if (col != '0) begin
                    col       <= col_dec;
                    write_adv <= 1'b0;
                    o_we      <= 1'b1;
                    o_address <= {row, col_dec};
                    o_data    <= CH_SP;
                    state     <= S_WRITE;
                  end
                end
                default: begin
                  write_adv <= 1'b1;
                  o_we      <= 1'b1;
                  o_address <= {row, col};
                  o_data    <= i_data;
                  state     <= S_WRITE;
                end
              endcase
            end
          end

          S_WRITE: begin
            state <= S_IDLE;
            if (write_adv) begin
              if (!last_col) begin
                col <= col + 1'b1;
              end else begin
                col <= '0;
                row <= adv_row;
                if (SCROLL) begin
                  state     <= S_LINECLR;
                  clr_col   <= '0;
                  o_we      <= 1'b1;
                  o_address <= {adv_row, {COL_W{1'b0}}};
                  o_data    <= CH_SP;
                end else if (last_row) begin
                  state <= S_FULL;
                end
              end
            end
          end

          S_CLEAR: begin
            if (clr_done) begin
              state <= S_IDLE;
              row   <= '0;
              col   <= '0;
            end else begin
              clr_row   <= clr_row_nxt;
              clr_col   <= clr_col_nxt;
              o_we      <= 1'b1;
              o_address <= {clr_row_nxt, clr_col_nxt};
              o_data    <= CH_SP;
            end
          end

          S_LINECLR: begin
            // The cursor already sits at column 0 of the row being blanked.
            if (clr_col == LAST_COL) begin
              state <= S_IDLE;
            end else begin
              clr_col   <= clr_col_nxt;
              o_we      <= 1'b1;
              o_address <= {row, clr_col_nxt};
              o_data    <= CH_SP;
            end
          end

          S_FULL: begin
            state <= S_FULL;
          end

          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_text_console_writer.sv
`timescale 1ns/1ps
module tb_text_console_writer;

  localparam int COLS   = 80;
  localparam int ROWS   = 30;
  localparam int ADDR_W = 12;
  localparam int LIMIT  = 3000;

`ifdef TEXT_CONSOLE_SCROLL_WRAP_EN
  localparam bit SCROLL = 1'b1;
`else
  localparam bit SCROLL = 1'b0;
`endif

  logic              i_clk = 1'b0;
  logic              i_rst;
  logic              i_valid;
  logic [7:0]        i_data;
  logic              i_clean;
  logic              o_ready;
  logic [ADDR_W-1:0] o_address;
  logic [7:0]        o_data;
  logic              o_we;
  logic              o_full;
  logic              o_busy;

  text_console_writer #(
    .COLS (COLS),
    .ROWS (ROWS),
    .COL_W(7),
    .ROW_W(5)
  ) dut (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_valid  (i_valid),
    .i_data   (i_data),
    .o_ready  (o_ready),
    .i_clean  (i_clean),
    .o_address(o_address),
    .o_data   (o_data),
    .o_we     (o_we),
    .o_full   (o_full),
    .o_busy   (o_busy)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_wr;
  int  vectors     = 0;
  int  miscompares = 0;
  int  m_row;
  int  m_col;
  bit  m_full;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: screen cursor plus the ordered list of cell writes.
  function automatic void push_wr(input int r, input int c, input logic [7:0] d);
    wr_t w;
    w.addr = ADDR_W'(r * 128 + c);
    w.data = d;
    exp_q.push_back(w);
  endfunction

  function automatic void model_reset();
    m_row  = 0;
    m_col  = 0;
    m_full = 1'b0;
  endfunction

  function automatic void model_newline();
    m_col = 0;
    if (SCROLL) begin
      m_row = (m_row + 1) % ROWS;
      for (int c = 0; c < COLS; c++) push_wr(m_row, c, 8'h20);
    end else if (m_row == ROWS - 1) begin
      m_row  = 0;
      m_full = 1'b1;
    end else begin
      m_row = m_row + 1;
    end
  endfunction

  function automatic void model_byte(input logic [7:0] b);
    case (b)
      8'h0A: model_newline();
      8'h0D: m_col = 0;
      8'h08: begin
        if (m_col > 0) begin
          m_col = m_col - 1;
          push_wr(m_row, m_col, 8'h20);
        end
      end
      default: begin
        push_wr(m_row, m_col, b);
        if (m_col == COLS - 1) model_newline();
        else m_col = m_col + 1;
      end
    endcase
  endfunction

  function automatic void model_clean();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        push_wr(r, c, 8'h20);
    model_reset();
  endfunction

  // Every observed write must be the next one the model predicts.
  always @(negedge i_clk) begin
    if (!i_rst && o_we) begin
      check_output("write_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        mon_wr = exp_q.pop_front();
        check_output("write_addr", 32'(o_address), 32'(mon_wr.addr));
        check_output("write_data", 32'(o_data), 32'(mon_wr.data));
      end
    end
  end

  task automatic apply_stimulus(input logic [7:0] b);
    int cnt = 0;
    @(negedge i_clk);
    while (!o_ready && cnt < LIMIT) begin
      @(negedge i_clk);
      cnt++;
    end
    check_output("ready_wait", 32'(o_ready), 32'd1);
    i_valid = 1'b1;
    i_data  = b;
    model_byte(b);
    @(negedge i_clk);
    i_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int cnt = 0;
    while (exp_q.size() != 0 && cnt < LIMIT) begin
      @(negedge i_clk);
      cnt++;
    end
    check_output("drain", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_ready();
    int cnt = 0;
    @(negedge i_clk);
    while (!o_ready && cnt < LIMIT) begin
      @(negedge i_clk);
      cnt++;
    end
    check_output("ready_after_busy", 32'(o_ready), 32'd1);
  endtask

  task automatic do_reset();
    @(negedge i_clk);
    i_rst = 1'b1;
    exp_q.delete();
    model_reset();
    @(negedge i_clk);
    i_rst = 1'b0;
  endtask

  task automatic do_clean();
    @(negedge i_clk);
    i_clean = 1'b1;
    model_clean();
    @(negedge i_clk);
    i_clean = 1'b0;
    check_output("clean_busy", 32'(o_busy), 32'd1);
    check_output("clean_not_ready", 32'(o_ready), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    i_rst   = 1'b0;
    i_valid = 1'b0;
    i_data  = 8'h00;
    i_clean = 1'b0;
    model_reset();
    #1 i_rst = 1'b1;

    // Reset state
    @(negedge i_clk);
    check_output("rst_ready", 32'(o_ready), 32'd1);
    check_output("rst_we", 32'(o_we), 32'd0);
    check_output("rst_full", 32'(o_full), 32'd0);
    check_output("rst_busy", 32'(o_busy), 32'd0);
    check_output("rst_addr", 32'(o_address), 32'd0);
    check_output("rst_data", 32'(o_data), 32'd0);
    @(negedge i_clk);
    i_rst = 1'b0;

    // "Hi", then to column 5, LF and 'A'
    apply_stimulus(8'h48);
    apply_stimulus(8'h69);
    apply_stimulus(8'h61);
    apply_stimulus(8'h62);
    apply_stimulus(8'h63);
    wait_drain();
    apply_stimulus(8'h0A);
    check_output("lf_busy", 32'(o_busy), 32'(SCROLL));
    apply_stimulus(8'h41);
    wait_drain();

    // Full row of 'x', wrap, backspace, backspace at column 0
    do_reset();
    for (int i = 0; i < COLS; i++) apply_stimulus(8'h78);
    apply_stimulus(8'h79);
    apply_stimulus(8'h08);
    apply_stimulus(8'h08);
    apply_stimulus(8'h71);
    apply_stimulus(8'h0D);
    apply_stimulus(8'h72);
    wait_drain();

`ifdef TEXT_CONSOLE_SCROLL_WRAP_EN
    // Wrap from the last row blanks row 0 before new text lands there
    do_reset();
    for (int i = 0; i < ROWS - 1; i++) apply_stimulus(8'h0A);
    for (int i = 0; i < 10; i++) apply_stimulus(8'h61);
    wait_drain();
    apply_stimulus(8'h0A);
    check_output("wrap_busy", 32'(o_busy), 32'd1);
    apply_stimulus(8'h42);
    wait_drain();
    @(negedge i_clk);
    check_output("wrap_not_full", 32'(o_full), 32'd0);
`else
    // Fill the screen, see FULL, then clean
    do_reset();
    for (int i = 0; i < ROWS - 1; i++) apply_stimulus(8'h0A);
    for (int i = 0; i < COLS - 1; i++) apply_stimulus(8'h61);
    apply_stimulus(8'h7A);
    wait_drain();
    @(negedge i_clk);
    check_output("full_flag", 32'(o_full), 32'd1);
    check_output("full_not_ready", 32'(o_ready), 32'd0);
    i_valid = 1'b1;
    i_data  = 8'h77;
    repeat (3) @(negedge i_clk);
    i_valid = 1'b0;
    check_output("full_holds", 32'(o_full), 32'd1);
    do_clean();
    wait_ready();
    wait_drain();
    check_output("clean_not_full", 32'(o_full), 32'd0);
`endif

    // Clean and valid in the same cycle: byte dropped, clear starts
    apply_stimulus(8'h55);
    wait_drain();
    @(negedge i_clk);
    i_valid = 1'b1;
    i_data  = 8'h51;
    i_clean = 1'b1;
    model_clean();
    @(negedge i_clk);
    i_valid = 1'b0;
    i_clean = 1'b0;
    check_output("cv_busy", 32'(o_busy), 32'd1);
    check_output("cv_not_ready", 32'(o_ready), 32'd0);
    wait_ready();
    wait_drain();

    // Reset in the middle of a clear aborts it
    apply_stimulus(8'h6B);
    do_clean();
    repeat (50) @(negedge i_clk);
    #2 i_rst = 1'b1;
    #1;
    check_output("midclr_we", 32'(o_we), 32'd0);
    check_output("midclr_busy", 32'(o_busy), 32'd0);
    check_output("midclr_addr", 32'(o_address), 32'd0);
    exp_q.delete();
    model_reset();
    @(negedge i_clk);
    i_rst = 1'b0;
    apply_stimulus(8'h72);
    wait_drain();

    // Random byte stream
    for (int i = 0; i < 400; i++) begin
      int r;
      logic [7:0] b;
      if (m_full) begin
        wait_drain();
        @(negedge i_clk);
        check_output("rand_full", 32'(o_full), 32'd1);
        check_output("rand_full_ready", 32'(o_ready), 32'd0);
        do_clean();
        wait_ready();
        wait_drain();
      end
      r = int'($urandom_range(0, 19));
      if (r < 2)       b = 8'h0A;
      else if (r == 2) b = 8'h0D;
      else if (r == 3) b = 8'h08;
      else             b = 8'($urandom_range(33, 126));
      apply_stimulus(b);
    end
    wait_drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
